axis_bram_adapter_v1_0_sched: RTL and testbench
===============================================

Name: axis_bram_adapter_v1_0_sched

Overview:
- Job sequencer in front of the AXIS-BRAM adapter controller.
- Queues transfer descriptors (direction, start row, bound row) and drives the adapter's rw, index range and reset for each job.
- Gates both stream handshakes so beats reach the adapter only while a job runs, and counts beats or detects tlast to retire the job.
- Reports done/error status to the host-side control logic.

Parameters:
- BRAM_ADDR_LENGTH, 12, row address width.
- BRAM_WIDTH_IN_WORD, 36, stream words per BRAM row.
- CMD_DEPTH, 4, descriptor FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  FIFO not full.
- cmd_rw  in  1  1 = stream-to-BRAM write, 0 = BRAM-to-stream read.
- cmd_start  in  BRAM_ADDR_LENGTH  first row.
- cmd_bound  in  BRAM_ADDR_LENGTH  last row (inclusive).
- abort  in  1  flush queue, kill current job.
- up_in_valid  in  1  upstream write-stream valid.
- up_in_ready  out  1  upstream write-stream ready.
- dn_out_valid  out  1  downstream read-stream valid.
- dn_out_accep  in  1  downstream read-stream accept.
- adp_rstn  out  1  adapter reset (active low).
- adp_rw  out  1  adapter rw.
- adp_start_index  out  BRAM_ADDR_LENGTH  adapter start index.
- adp_bound_index  out  BRAM_ADDR_LENGTH  adapter bound index.
- adp_in_valid  out  1  gated stream_in_valid to adapter.
- adp_out_accep  out  1  gated stream_out_accep to adapter.
- adp_out_tlast  in  1  adapter stream_out_tlast.
- busy  out  1  job in LOAD/SETTLE/RUN/DONE.
- done  out  1  one-cycle pulse, job retired.
- err  out  1  one-cycle pulse, descriptor rejected or job aborted.

Behaviour:
- Reset values: state IDLE, FIFO empty, adp_rstn=0, adp_rw=1, adp indices 0, beat counter 0. busy, done, err, up_in_ready, dn_out_valid, adp_in_valid and adp_out_accep are all 0. cmd_ready=1.
- FIFO: push when cmd_valid && cmd_ready. cmd_ready = !full. A push and a pop in the same cycle are both honoured.
- FSM states: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE:
  - adp_rstn=1.
  - If the FIFO is non-empty, pop the head and latch rw/start/bound.
  - If bound < start: pulse err, discard, stay in IDLE.
  - Otherwise go to LOAD.
- LOAD (exactly 1 cycle): adp_rstn=0, adp_rw/adp_start_index/adp_bound_index = latched values. This forces the adapter index to start and clears its word counter. Then go to SETTLE.
- SETTLE (exactly 1 cycle): adp_rstn=1, streams gated off. This lets the adapter's rw history settle and reload its index. Then go to RUN.
- RUN, write (rw=1):
  - up_in_ready=1 and adp_in_valid=up_in_valid.
  - Each beat (up_in_valid in RUN) increments the beat counter.
  - When the counter is at (bound-start+1)*BRAM_WIDTH_IN_WORD-1 and a beat occurs, go to DONE. That beat is the last one accepted.
  - Counter width is BRAM_ADDR_LENGTH+6 and the product must not overflow.
- RUN, read (rw=0):
  - dn_out_valid=1 and adp_out_accep=dn_out_accep.
  - A beat with adp_out_tlast=1 and dn_out_accep=1 is the last; go to DONE.
- DONE (1 cycle): streams gated off, done=1. This covers the adapter's final BRAM write. Then go to IDLE.
- Minimum job latency, IDLE to first beat: IDLE, LOAD, SETTLE, so the first beat is accepted on the 3rd cycle after the pop decision. Back-to-back jobs repeat LOAD/SETTLE even when rw is unchanged.
- adp_rw and the indices hold their last job's values in IDLE/DONE.
- Outside RUN, up_in_ready, dn_out_valid, adp_in_valid and adp_out_accep are all 0.
- abort (synchronous, any state): flush the FIFO, clear the counter, go to IDLE next cycle.
  - If state was LOAD/SETTLE/RUN, pulse err and drive adp_rstn=0 for that cycle.
  - abort has priority over a cmd push in the same cycle; that push is dropped.
- Asynchronous rst mid-job: everything returns to reset values immediately. adp_rstn=0 holds the adapter in reset while rst is asserted.

Test Plan:
- Write job rw=1, start=2, bound=3, up_in_valid held high -> 72 beats accepted, adp_start_index=2, done pulses 1 cycle after beat 72, then up_in_ready=0.
- Read job rw=0, start=0, bound=1, dn_out_accep toggled 1/0 -> dn_out_valid high in RUN only, exits on the tlast handshake, done=1 once.
- Push 4 descriptors back-to-back with CMD_DEPTH=4 while a job runs -> cmd_ready=0 after the 4th push while the head job runs, and each job executes in order with a LOAD pulse on adp_rstn.
- Descriptor start=5, bound=4 -> err pulse, no LOAD, next descriptor executes normally.
- abort asserted at beat 10 of a write job with 2 queued -> err pulse, FIFO empty, state IDLE, adp_rstn low for one cycle, no further beats accepted.
- rst asserted mid-RUN asynchronously -> all outputs at reset values before the next clk edge, cmd_ready=1 after release.

Source files
------------

// File: rtl/axis_bram_adapter_v1_0_sched.sv
`default_nettype none
// ============================================================================
//  Module   : axis_bram_adapter_v1_0_sched
//  Purpose  : Job sequencer placed in front of the AXIS-BRAM adapter
//             controller. Host-side logic queues transfer descriptors
//             (direction, first row, last row). Each job then runs as:
//               IDLE   - pop a descriptor and validate it
//               LOAD   - hold the adapter in reset with the new rw/indices
//               SETTLE - release the adapter, streams still gated
//               RUN    - pass stream handshakes through until the last beat
//               DONE   - gate streams while the adapter finishes its write
//             In RUN the job retires on a beat count (write) or on the
//             adapter's tlast handshake (read).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                  clock, asynchronous active-high reset
//    cmd_valid / cmd_ready     descriptor push handshake (ready = FIFO not full)
//    cmd_rw                    1 = stream-to-BRAM write, 0 = BRAM-to-stream read
//    cmd_start / cmd_bound     first / last (inclusive) BRAM row
//    abort                     flush the queue and kill the current job
//    up_in_valid / up_in_ready upstream write stream, gated by the job state
//    dn_out_valid/dn_out_accep downstream read stream, gated by the job state
//    adp_rstn                  adapter reset (active low)
//    adp_rw, adp_start_index,
//    adp_bound_index           adapter job setup
//    adp_in_valid              gated stream_in_valid to the adapter
//    adp_out_accep             gated stream_out_accep to the adapter
//    adp_out_tlast             adapter stream_out_tlast
//    busy                      a job is in LOAD/SETTLE/RUN/DONE
//    done                      one-cycle pulse when a job retires
//    err                       one-cycle pulse on a rejected descriptor or abort
// ============================================================================
module axis_bram_adapter_v1_0_sched #(
    parameter int BRAM_ADDR_LENGTH   = 12,
    parameter int BRAM_WIDTH_IN_WORD = 36,
    parameter int CMD_DEPTH          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rw,
    input  logic [BRAM_ADDR_LENGTH-1:0] cmd_start,
    input  logic [BRAM_ADDR_LENGTH-1:0] cmd_bound,
    input  logic                        abort,
    input  logic                        up_in_valid,
    output logic                        up_in_ready,
    output logic                        dn_out_valid,
    input  logic                        dn_out_accep,
    output logic                        adp_rstn,
    output logic                        adp_rw,
    output logic [BRAM_ADDR_LENGTH-1:0] adp_start_index,
    output logic [BRAM_ADDR_LENGTH-1:0] adp_bound_index,
    output logic                        adp_in_valid,
    output logic                        adp_out_accep,
    input  logic                        adp_out_tlast,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Six extra counter bits cover up to 64 words per row times every row.
    localparam int c_cnt_w = BRAM_ADDR_LENGTH + 6;
    localparam int c_ptr_w = $clog2(CMD_DEPTH);
    localparam int c_ent_w = 2 * BRAM_ADDR_LENGTH + 1;

    localparam logic [c_cnt_w-1:0] c_words = c_cnt_w'(BRAM_WIDTH_IN_WORD);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(CMD_DEPTH);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_settle = 3'd2;
    localparam logic [2:0] c_st_run    = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]                  r_state;
    logic [2:0]                  w_state_nxt;

    logic [c_ent_w-1:0]          r_fifo_mem [CMD_DEPTH];
    logic [c_ptr_w-1:0]          r_wr_ptr;
    logic [c_ptr_w-1:0]          r_rd_ptr;
    logic [c_ptr_w:0]            r_count;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_launch;

    logic [c_ent_w-1:0]          w_head;
    logic                        w_head_rw;
    logic [BRAM_ADDR_LENGTH-1:0] w_head_start;
    logic [BRAM_ADDR_LENGTH-1:0] w_head_bound;
    logic                        w_head_bad;
    logic [BRAM_ADDR_LENGTH:0]   w_rows;
    logic [c_cnt_w-1:0]          w_last_beat;

    logic                        r_rw;
    logic [BRAM_ADDR_LENGTH-1:0] r_start;
    logic [BRAM_ADDR_LENGTH-1:0] r_bound;
    logic [c_cnt_w-1:0]          r_last_beat;
    logic [c_cnt_w-1:0]          r_beat_cnt;

    logic                        w_active;
    logic                        w_wr_beat;
    logic                        w_wr_last;
    logic                        w_rd_last;
    logic                        w_kill;

    // ------------------------------------------------------------------------
    // Descriptor FIFO
    // ------------------------------------------------------------------------
    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign cmd_ready = ~w_full;

    // abort flushes the queue, so a push in the same cycle is dropped.
    assign w_push = cmd_valid & ~w_full & ~abort;
    // The head is consumed in IDLE whether it is accepted or rejected.
    assign w_pop  = (r_state == c_st_idle) & ~w_empty & ~abort;

    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_head_rw    = w_head[c_ent_w-1];
    assign w_head_start = w_head[2*BRAM_ADDR_LENGTH-1:BRAM_ADDR_LENGTH];
    assign w_head_bound = w_head[BRAM_ADDR_LENGTH-1:0];
    assign w_head_bad   = (w_head_bound < w_head_start);
    assign w_launch     = w_pop & ~w_head_bad;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {cmd_rw, cmd_start, cmd_bound};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Job setup and beat counter
    // ------------------------------------------------------------------------
    // Index of the final write beat: rows * words_per_row - 1. Rows fits in
    // one extra bit and the product fits in the widened counter.
    assign w_rows      = {1'b0, w_head_bound} - {1'b0, w_head_start} + 1'b1;
    assign w_last_beat = (c_cnt_w'(w_rows) * c_words) - 1'b1;

    assign w_active  = (r_state == c_st_run);
    assign w_wr_beat = w_active & r_rw & up_in_valid;
    assign w_wr_last = w_wr_beat & (r_beat_cnt == r_last_beat);
    assign w_rd_last = w_active & ~r_rw & dn_out_accep & adp_out_tlast;

    // Only a validated descriptor touches the adapter setup, so a rejected
    // one leaves the previous job's values on adp_rw and the indices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw        <= 1'b1;
            r_start     <= '0;
            r_bound     <= '0;
            r_last_beat <= '0;
        end else if (w_launch) begin
            r_rw        <= w_head_rw;
            r_start     <= w_head_start;
            r_bound     <= w_head_bound;
            r_last_beat <= w_last_beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (abort || (r_state == c_st_load)) begin
            r_beat_cnt <= '0;
        end else if (w_wr_beat) begin
            r_beat_cnt <= w_wr_last ? '0 : (r_beat_cnt + 1'b1);
        end
    end

    assign adp_rw          = r_rw;
    assign adp_start_index = r_start;
    assign adp_bound_index = r_bound;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_launch) begin
                        w_state_nxt = c_st_load;
                    end
                end
                c_st_load:   w_state_nxt = c_st_settle;
                c_st_settle: w_state_nxt = c_st_run;
                c_st_run: begin
                    if (w_wr_last || w_rd_last) begin
                        w_state_nxt = c_st_done;
                    end
                end
                c_st_done:   w_state_nxt = c_st_idle;
                default:     w_state_nxt = c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // A job is killed when abort lands while the adapter is being set up or
    // streaming; DONE has already delivered every beat so it is not a kill.
    assign w_kill = abort & ((r_state == c_st_load)   |
                             (r_state == c_st_settle) |
                             (r_state == c_st_run));

    always_comb begin
        adp_rstn      = 1'b1;
        up_in_ready   = 1'b0;
        adp_in_valid  = 1'b0;
        dn_out_valid  = 1'b0;
        adp_out_accep = 1'b0;
        done          = 1'b0;
        busy          = (r_state != c_st_idle);
        err           = (w_pop & w_head_bad) | w_kill;

        case (r_state)
            c_st_load: begin
                // Forces the adapter index to start and clears its word count.
                adp_rstn = 1'b0;
            end
            c_st_run: begin
                if (r_rw) begin
                    up_in_ready  = 1'b1;
                    adp_in_valid = up_in_valid;
                end else begin
                    dn_out_valid  = 1'b1;
                    adp_out_accep = dn_out_accep;
                end
            end
            c_st_done: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase

        if (w_kill) begin
            adp_rstn = 1'b0;
        end
        // Hold the adapter in reset for as long as rst is asserted, not just
        // from the next clock edge.
        if (rst) begin
            adp_rstn = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_bram_adapter_v1_0_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_bram_adapter_v1_0_sched
//  Purpose  : Self-checking bench for axis_bram_adapter_v1_0_sched. A table of
//             write descriptors with hand-computed beat counts, followed by
//             directed sequences for reads, a full queue, a rejected
//             descriptor, abort and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_bram_adapter_v1_0_sched;

    localparam int AW = 12;
    localparam int WW = 36;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rw;
    logic [AW-1:0] cmd_start;
    logic [AW-1:0] cmd_bound;
    logic          abort;
    logic          up_in_valid;
    logic          up_in_ready;
    logic          dn_out_valid;
    logic          dn_out_accep;
    logic          adp_rstn;
    logic          adp_rw;
    logic [AW-1:0] adp_start_index;
    logic [AW-1:0] adp_bound_index;
    logic          adp_in_valid;
    logic          adp_out_accep;
    logic          adp_out_tlast;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    axis_bram_adapter_v1_0_sched #(
        .BRAM_ADDR_LENGTH  (AW),
        .BRAM_WIDTH_IN_WORD(WW),
        .CMD_DEPTH         (DP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rw         (cmd_rw),
        .cmd_start      (cmd_start),
        .cmd_bound      (cmd_bound),
        .abort          (abort),
        .up_in_valid    (up_in_valid),
        .up_in_ready    (up_in_ready),
        .dn_out_valid   (dn_out_valid),
        .dn_out_accep   (dn_out_accep),
        .adp_rstn       (adp_rstn),
        .adp_rw         (adp_rw),
        .adp_start_index(adp_start_index),
        .adp_bound_index(adp_bound_index),
        .adp_in_valid   (adp_in_valid),
        .adp_out_accep  (adp_out_accep),
        .adp_out_tlast  (adp_out_tlast),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int load_starts[$];

    typedef struct {
        int start;
        int bound;
        int exp_beats;
        int exp_err;
        int exp_first;
        int exp_idx;
        int exp_bnd;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push(input logic rw, input int s, input int b);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_start = AW'(s);
        cmd_bound = AW'(b);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Samples once per negedge with inputs held steady.
    task automatic monitor(input int budget, input int want_done,
                           output int beats, output int loads, output int errs,
                           output int dones, output int first_beat);
        beats = 0; loads = 0; errs = 0; dones = 0; first_beat = -1;
        for (int i = 0; i < budget; i++) begin
            if (!adp_rstn) begin
                loads++;
                load_starts.push_back(int'(adp_start_index));
            end
            if (up_in_ready && up_in_valid) begin
                if (first_beat < 0) first_beat = i;
                beats++;
            end
            if (err)  errs++;
            if (done) dones++;
            if (want_done > 0 && dones >= want_done) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, loads, errs, dones, first;
        int hs, run_cyc, bad_valid, accep_mis, nb;

        vecs[0] = '{start: 2,    bound: 3,    exp_beats: 72,  exp_err: 0, exp_first: 3,  exp_idx: 2,    exp_bnd: 3};
        vecs[1] = '{start: 5,    bound: 4,    exp_beats: 0,   exp_err: 1, exp_first: -1, exp_idx: 2,    exp_bnd: 3};
        vecs[2] = '{start: 4095, bound: 4095, exp_beats: 36,  exp_err: 0, exp_first: 3,  exp_idx: 4095, exp_bnd: 4095};
        vecs[3] = '{start: 0,    bound: 0,    exp_beats: 36,  exp_err: 0, exp_first: 3,  exp_idx: 0,    exp_bnd: 0};
        vecs[4] = '{start: 10,   bound: 12,   exp_beats: 108, exp_err: 0, exp_first: 3,  exp_idx: 10,   exp_bnd: 12};

        cmd_valid = 0; cmd_rw = 0; cmd_start = '0; cmd_bound = '0; abort = 0;
        up_in_valid = 0; dn_out_accep = 0; adp_out_tlast = 0;

        // ---------------- reset values ----------------
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_adp_rstn", adp_rstn, 0);
        check("rst_adp_rw", adp_rw, 1);
        check("rst_adp_start", int'(adp_start_index), 0);
        check("rst_busy", busy, 0);
        check("rst_up_in_ready", up_in_ready, 0);
        check("rst_dn_out_valid", dn_out_valid, 0);
        check("rst_done_err", {done, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_adp_rstn", adp_rstn, 1);

        // ---------------- table: write descriptors ----------------
        up_in_valid = 1'b1;
        for (int v = 0; v < 5; v++) begin
            load_starts.delete();
            push(1'b1, vecs[v].start, vecs[v].bound);
            monitor(vecs[v].exp_beats + 20, (vecs[v].exp_err != 0) ? 0 : 1,
                    beats, loads, errs, dones, first);
            check($sformatf("vec%0d_beats", v), beats, vecs[v].exp_beats);
            check($sformatf("vec%0d_err", v), errs, vecs[v].exp_err);
            check($sformatf("vec%0d_loads", v), loads, 1 - vecs[v].exp_err);
            check($sformatf("vec%0d_done", v), dones, 1 - vecs[v].exp_err);
            check($sformatf("vec%0d_first_beat", v), first, vecs[v].exp_first);
            check($sformatf("vec%0d_start_idx", v), int'(adp_start_index), vecs[v].exp_idx);
            check($sformatf("vec%0d_bound_idx", v), int'(adp_bound_index), vecs[v].exp_bnd);
            @(negedge clk);
            check($sformatf("vec%0d_after_busy", v), busy, 0);
            check($sformatf("vec%0d_after_ready", v), up_in_ready, 0);
        end

        // ---------------- read job with toggling accept ----------------
        up_in_valid = 1'b0;
        hs = 0; run_cyc = 0; bad_valid = 0; accep_mis = 0; dones = 0; errs = 0;
        push(1'b0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            dn_out_accep  = (i % 2 == 0);
            adp_out_tlast = (hs >= 4);
            #1;
            if (dn_out_valid) run_cyc++;
            if (dn_out_valid && (done || !adp_rstn)) bad_valid++;
            if (adp_out_accep != (dn_out_valid & dn_out_accep)) accep_mis++;
            if (dn_out_valid && dn_out_accep) hs++;
            if (done) dones++;
            if (err)  errs++;
            @(negedge clk);
        end
        check("rd_handshakes", hs, 5);
        check("rd_run_cycles", run_cyc, 10);
        check("rd_valid_outside_run", bad_valid, 0);
        check("rd_accep_gating", accep_mis, 0);
        check("rd_done_once", dones, 1);
        check("rd_err", errs, 0);
        check("rd_adp_rw_hold", adp_rw, 0);
        dn_out_accep = 0; adp_out_tlast = 0;

        // ---------------- full queue behind a stalled job ----------------
        push(1'b1, 0, 0);
        repeat (3) @(negedge clk);
        check("fifo_jobA_run", up_in_ready, 1);
        check("fifo_gate_in_low", adp_in_valid, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fifo_ready_push%0d", k), cmd_ready, 1);
            cmd_valid = 1'b1; cmd_rw = 1'b1;
            cmd_start = AW'(k + 1); cmd_bound = AW'(k + 1);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("fifo_full_ready", cmd_ready, 0);
        load_starts.delete();
        up_in_valid = 1'b1;
        monitor(400, 5, beats, loads, errs, dones, first);
        check("fifo_dones", dones, 5);
        check("fifo_beats", beats, 180);
        check("fifo_loads", loads, 4);
        check("fifo_errs", errs, 0);
        for (int k = 0; k < 4; k++) begin
            int got;
            got = (k < load_starts.size()) ? load_starts[k] : -1;
            check($sformatf("fifo_order%0d", k), got, k + 1);
        end
        @(negedge clk);
        check("fifo_ready_after", cmd_ready, 1);

        // ---------------- rejected descriptor then a good one ----------------
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_start = AW'(5); cmd_bound = AW'(4);
        @(negedge clk);
        check("bad_desc_err", err, 1);
        cmd_start = AW'(6); cmd_bound = AW'(6);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bad_desc_no_load", adp_rstn, 1);
        check("bad_desc_busy", busy, 0);
        load_starts.delete();
        monitor(80, 1, beats, loads, errs, dones, first);
        check("good_after_bad_beats", beats, 36);
        check("good_after_bad_loads", loads, 1);
        check("good_after_bad_first", first, 3);
        check("good_after_bad_start", int'(adp_start_index), 6);
        @(negedge clk);

        // ---------------- abort at beat 10 with two queued ----------------
        up_in_valid = 1'b0;
        push(1'b1, 0, 1);
        repeat (3) @(negedge clk);
        push(1'b1, 7, 7);
        push(1'b1, 8, 8);
        up_in_valid = 1'b1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (up_in_ready && up_in_valid) nb++;
            if (nb >= 9) break;
            @(negedge clk);
        end
        check("abort_pre_beats", nb, 9);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_err", err, 1);
        check("abort_adp_rstn", adp_rstn, 0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_rstn", adp_rstn, 1);
        check("abort_cmd_ready", cmd_ready, 1);
        monitor(12, 0, beats, loads, errs, dones, first);
        check("abort_no_beats", beats, 0);
        check("abort_no_loads", loads, 0);
        check("abort_no_done", dones + errs, 0);

        // ---------------- abort beats a push in the same cycle ----------------
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_start = AW'(1); cmd_bound = AW'(1);
        abort = 1'b1;
        #1;
        check("abort_idle_no_err", err, 0);
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        monitor(8, 0, beats, loads, errs, dones, first);
        check("abort_push_dropped", loads + beats + dones, 0);

        // ---------------- asynchronous reset mid-RUN ----------------
        up_in_valid = 1'b0; dn_out_accep = 1'b0;
        push(1'b0, 3, 3);
        repeat (5) @(negedge clk);
        check("arst_pre_dn_valid", dn_out_valid, 1);
        check("arst_pre_start", int'(adp_start_index), 3);
        #2 rst = 1'b1;
        #1;
        check("arst_adp_rstn", adp_rstn, 0);
        check("arst_busy", busy, 0);
        check("arst_dn_valid", dn_out_valid, 0);
        check("arst_adp_rw", adp_rw, 1);
        check("arst_start", int'(adp_start_index), 0);
        check("arst_bound", int'(adp_bound_index), 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_done_err", {done, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_release_rstn", adp_rstn, 1);
        check("arst_release_ready", cmd_ready, 1);
        check("arst_release_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
